// File: rtl/branch_resolve_unit.sv
// Branch resolution at the EX end of the branch-hazard interface: condition decode, PC redirect
// handshake to fetch, then a fixed-length flush. Optional statistics counters under BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [2:0]       funct3,
    input  logic             V,
    input  logic             C,
    input  logic             N,
    input  logic             Z,
    input  logic             L,
    input  logic [XLEN-1:0]  pc_prev,
    input  logic [XLEN-1:0]  imm,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic             flush_n,
    output logic             stall,
    output logic             br_exc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // state    | meaning
    // IDLE     | sampling br_valid, pipeline free-running
    // REDIRECT | redir_valid high, waiting for fetch to accept redir_pc
    // FLUSH    | flush_n low for FLUSH_CYCLES cycles, upstream stalled
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    generate
        if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
            $error("branch_resolve_unit: FLUSH_CYCLES must be >= 1");
        end
    endgenerate

    state_t          state;
    logic [FC_W-1:0] flush_cnt;
    logic            cond;
    logic            legal;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            take_ok;
    logic            exc_next;
    logic            unused_c;

    // Carry is not needed by any RV32 branch condition.
    assign unused_c = C;

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            3'b000:  cond = Z;
            3'b001:  cond = ~Z;
            3'b100:  cond = N ^ V;
            3'b101:  cond = ~(N ^ V);
            3'b110:  cond = L;
            3'b111:  cond = ~L;
            default: legal = 1'b0;
        endcase
    end

    assign target     = pc_prev + imm;
    assign misaligned = (target[1:0] != 2'b00);
    assign take_ok    = br_valid && legal && cond && !misaligned;
    assign exc_next   = br_valid && (!legal || (cond && misaligned));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            flush_n     <= 1'b1;
            stall       <= 1'b0;
            br_exc      <= 1'b0;
        end else begin
            br_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_ok) begin
                        state       <= REDIRECT;
                        redir_pc    <= target;
                        redir_valid <= 1'b1;
                        stall       <= 1'b1;
                    end else if (exc_next) begin
                        br_exc <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redir_ready) begin
                        state       <= FLUSH;
                        flush_cnt   <= FC_W'(FLUSH_CYCLES - 1);
                        redir_valid <= 1'b0;
                        flush_n     <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= IDLE;
                        flush_n <= 1'b1;
                        stall   <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    redir_valid <= 1'b0;
                    flush_n     <= 1'b1;
                    stall       <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (state == IDLE && br_valid && legal)
                br_cnt_q <= br_cnt_q + 1'b1;
            if (state == REDIRECT && redir_ready)
                taken_cnt_q <= taken_cnt_q + 1'b1;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`else
    assign br_cnt    = '0;
    assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized branches,
// flags derived from random rs1/rs2 operands and checked against a transaction-level model.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int FC    = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             br_valid = 1'b0;
    logic [2:0]       funct3 = 3'b000;
    logic             f_v = 1'b0, f_c = 1'b0, f_n = 1'b0, f_z = 1'b0, f_l = 1'b0;
    logic [XLEN-1:0]  pc_prev = '0;
    logic [XLEN-1:0]  imm = '0;
    logic             redir_valid;
    logic             redir_ready = 1'b1;
    logic [XLEN-1:0]  redir_pc;
    logic             flush_n;
    logic             stall;
    logic             br_exc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    logic [XLEN-1:0]  rs1 = '0, rs2 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .funct3(funct3),
        .V(f_v), .C(f_c), .N(f_n), .Z(f_z), .L(f_l),
        .pc_prev(pc_prev), .imm(imm),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .flush_n(flush_n), .stall(stall), .br_exc(br_exc),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // Transaction-level model: a pending redirect, a count of flush cycles still owed,
    // and the branch decision taken straight from the operands.
    logic             m_redir = 1'b0;
    int               m_flush_left = 0;
    logic [XLEN-1:0]  m_pc = '0;
    logic             m_exc = 1'b0;
    logic [CNT_W-1:0] m_br = '0;
    logic [CNT_W-1:0] m_taken = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_redir      <= 1'b0;
            m_flush_left <= 0;
            m_exc        <= 1'b0;
            m_br         <= '0;
            m_taken      <= '0;
        end else begin
            automatic logic            legal = !(funct3 == 3'd2 || funct3 == 3'd3);
            automatic logic            tk = 1'b0;
            automatic logic [XLEN-1:0] tgt = pc_prev + imm;
            m_exc <= 1'b0;
            if (m_redir) begin
                if (redir_ready) begin
                    m_redir      <= 1'b0;
                    m_flush_left <= FC;
                    m_taken      <= m_taken + 1'b1;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left <= m_flush_left - 1;
            end else if (br_valid) begin
                case (funct3)
                    3'd0: tk = (rs1 == rs2);
                    3'd1: tk = (rs1 != rs2);
                    3'd4: tk = ($signed(rs1) <  $signed(rs2));
                    3'd5: tk = ($signed(rs1) >= $signed(rs2));
                    3'd6: tk = (rs1 <  rs2);
                    3'd7: tk = (rs1 >= rs2);
                    default: tk = 1'b0;
                endcase
                if (legal) m_br <= m_br + 1'b1;
                if (!legal || (tk && tgt[1:0] != 2'b00)) m_exc <= 1'b1;
                else if (tk) begin
                    m_redir <= 1'b1;
                    m_pc    <= tgt;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("redir_valid", 64'(redir_valid), 64'(m_redir));
        chk("flush_n", 64'(flush_n), 64'(m_flush_left == 0));
        chk("stall", 64'(stall), 64'(m_redir || m_flush_left > 0));
        chk("br_exc", 64'(br_exc), 64'(m_exc));
        if (m_redir) chk("redir_pc", 64'(redir_pc), 64'(m_pc));
`ifdef BRANCH_STATS_EN
        chk("br_cnt", 64'(br_cnt), 64'(m_br));
        chk("taken_cnt", 64'(taken_cnt), 64'(m_taken));
`else
        chk("br_cnt", 64'(br_cnt), 64'd0);
        chk("taken_cnt", 64'(taken_cnt), 64'd0);
`endif
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_ops(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        automatic logic [XLEN-1:0] d = a - b;
        rs1 = a;
        rs2 = b;
        f_z = (d == '0);
        f_n = d[XLEN-1];
        f_l = (a < b);
        f_c = !(a < b);
        f_v = (a[XLEN-1] != b[XLEN-1]) && (d[XLEN-1] != a[XLEN-1]);
    endtask

    task automatic launch(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] pc, input logic [XLEN-1:0] im);
        funct3   = f3;
        set_ops(a, b);
        pc_prev  = pc;
        imm      = im;
        br_valid = 1'b1;
        step();
        br_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        redir_ready = 1'b1;
        for (i = 0; i < 20; i++) begin
            if (!stall && !redir_valid) break;
            step();
        end
        if (i == 20) chk("wait_idle_timeout", 64'(stall), 64'd0);
    endtask

    task automatic window(input int n, output int r, output int f, output int s);
        r = 0; f = 0; s = 0;
        for (int i = 0; i < n; i++) begin
            r += int'(redir_valid);
            f += int'(!flush_n);
            s += int'(stall);
            step();
        end
    endtask

    initial begin
        int r, f, s, r2, f2, s2;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Taken BEQ with ready high
        redir_ready = 1'b1;
        launch(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        chk("t1_pc", 64'(redir_pc), 64'h120);
        window(8, r, f, s);
        chk("t1_redir_cycles", 64'(r), 64'd1);
        chk("t1_flush_cycles", 64'(f), 64'd2);
        chk("t1_stall_cycles", 64'(s), 64'd3);

        // Back-to-back not-taken BNE
        for (int i = 0; i < 5; i++) begin
            launch(3'b001, 32'd7, 32'd7, 32'h200, 32'h40);
            chk("t2_no_redir", 64'(redir_valid | stall | br_exc | !flush_n), 64'd0);
        end

        // BLT with ready low for four cycles
        redir_ready = 1'b0;
        launch(3'b100, 32'd1, 32'd2, 32'h300, 32'h10);
        chk("t3_pc", 64'(redir_pc), 64'h310);
        window(4, r, f, s);
        redir_ready = 1'b1;
        window(6, r2, f2, s2);
        chk("t3_redir_cycles", 64'(r + r2), 64'd5);
        chk("t3_flush_before_ready", 64'(f), 64'd0);
        chk("t3_flush_cycles", 64'(f2), 64'd2);

        // Illegal funct3, then misaligned taken BGEU
        launch(3'b010, 32'd1, 32'd1, 32'h100, 32'h4);
        chk("t4_exc_illegal", 64'(br_exc), 64'd1);
        step();
        chk("t4_exc_clear", 64'(br_exc), 64'd0);
        launch(3'b111, 32'd9, 32'd3, 32'h100, 32'h2);
        chk("t4_exc_misaligned", 64'(br_exc), 64'd1);
        chk("t4_no_redir", 64'(redir_valid), 64'd0);
        step();

        // Target wrap-around
        launch(3'b000, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h20);
        chk("t5_wrap_pc", 64'(redir_pc), 64'h10);
        wait_idle();

        // Async reset in FLUSH, then three branches (two taken)
        launch(3'b000, 32'd0, 32'd0, 32'h400, 32'h8);
        step();
        chk("t6_in_flush", 64'(flush_n), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_redir_valid", 64'(redir_valid), 64'd0);
        chk("t6_rst_redir_pc", 64'(redir_pc), 64'd0);
        chk("t6_rst_flush_n", 64'(flush_n), 64'd1);
        chk("t6_rst_stall", 64'(stall), 64'd0);
        chk("t6_rst_br_exc", 64'(br_exc), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        launch(3'b000, 32'd4, 32'd4, 32'h500, 32'hC);
        chk("t6_post_pc", 64'(redir_pc), 64'h50C);
        wait_idle();
        launch(3'b001, 32'd4, 32'd4, 32'h500, 32'hC);
        launch(3'b110, 32'd1, 32'd2, 32'h600, 32'hFFFF_FFFC);
        wait_idle();
`ifdef BRANCH_STATS_EN
        chk("t6_br_cnt", 64'(br_cnt), 64'd3);
        chk("t6_taken_cnt", 64'(taken_cnt), 64'd2);
`else
        chk("t6_br_cnt_off", 64'(br_cnt), 64'd0);
        chk("t6_taken_cnt_off", 64'(taken_cnt), 64'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            automatic logic [XLEN-1:0] a = $urandom;
            automatic logic [XLEN-1:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            br_valid    = ($urandom_range(0, 1) == 1);
            funct3      = 3'($urandom_range(0, 7));
            set_ops(a, b);
            pc_prev     = $urandom & 32'hFFFF_FFFC;
            imm         = ($urandom_range(0, 3) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            redir_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        br_valid = 1'b0;
        wait_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
